rr_dec_sel_arbiter: RTL
=======================

Name: rr_dec_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 2-to-4 decoder.
- Arbitrates 4 request lines and outputs a 2-bit index (`sel`) plus a valid/enable (`sel_vld`). These wire straight to the decoder's select and enable inputs, so the decoder output is the one-hot grant.
- Guarantees break-before-make: one dead cycle with `sel_vld` = 0 between consecutive grants.
- Optional maximum-hold timeout forces rotation.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles `sel_vld` stays high for one grant; legal range 2..255. Used only when the timeout feature is compiled in.
- HOLD_W, $clog2(MAX_HOLD), width of the internal hold counter. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request per channel; level-sensitive; requester holds it high for as long as it wants the grant.
- rel  input  1  one-cycle release pulse from the current owner; ignored when `sel_vld` = 0.
- sel  output  2  granted channel index; feeds the decoder select.
- sel_vld  output  1  grant valid; feeds the decoder enable.
- grant_start  output  1  one-cycle pulse in the first cycle of each grant.
- timeout  output  1  one-cycle pulse in the first cycle after a grant is ended by MAX_HOLD expiry.

Behaviour:
- All outputs are registered.
- Reset state:
  - `sel` = 0, `sel_vld` = 0, `grant_start` = 0, `timeout` = 0.
  - Internal pointer `ptr` = 0, hold counter = 0, state = IDLE.
  - Assertion of rst_n low clears everything immediately, including mid-grant.
- State machine: IDLE, GRANT, GAP.
- Arbitration function:
  - Picks the first asserted `req` bit, searching upward from index `ptr` and wrapping modulo 4 (`ptr`, `ptr`+1, ..., `ptr`+3).
  - Evaluated combinationally in IDLE and in GAP.
- IDLE:
  - `sel_vld` = 0.
  - If req != 0 in cycle N: at edge N+1 `sel` = winner, `sel_vld` = 1, `grant_start` = 1, hold counter = 0, go to GRANT.
  - If req == 0: stay in IDLE.
- GRANT:
  - `sel_vld` = 1. The hold counter increments each cycle and saturates.
  - End condition, evaluated each cycle, is any of:
    - (a) `req[sel]` = 0;
    - (b) `rel` = 1;
    - (c) the timeout feature is compiled in and the hold counter == MAX_HOLD-1.
  - On end at edge E: `sel_vld` = 0; `ptr` = (`sel`+1) mod 4; go to GAP.
  - `timeout` = 1 at edge E only if (c) is true and neither (a) nor (b) is true. Release takes precedence over timeout.
- GAP (exactly one cycle):
  - `sel_vld` = 0.
  - If any request is present, the arbitration result is granted at the next edge, as in IDLE. Otherwise go to IDLE.
  - Net effect: exactly one dead cycle between back-to-back grants.
- `sel` holds its last value while `sel_vld` = 0; the decoder output is all-zero in that state.
- `grant_start` and `timeout` are high for exactly one cycle and never high together.
- Latency: request to `sel_vld` = 1 is 1 cycle from IDLE or GAP. End condition to `sel_vld` = 0 is 1 cycle.
- Requests on other channels during GRANT have no effect until GAP.
- A `req` that drops and re-rises during GAP is seen only in its GAP-cycle value.

Optional Feature:
- Macro: RR_HOLD_TIMEOUT_EN.
- Defined: end condition (c) is active; every grant lasts at most MAX_HOLD cycles; `timeout` pulses as described above.
- Not defined: no hold counter logic; a grant lasts until `req[sel]` drops or `rel` pulses; `timeout` is tied to 0 and MAX_HOLD is unused.
- Port list is identical in both builds.

Test Plan:
- Reset check: rst_n low, then released with req = 4'b0000 → `sel` = 0, `sel_vld` = 0, `grant_start` = 0, `timeout` = 0, held for 5 cycles.
- Single request: req = 4'b0100 from IDLE at cycle N → at N+1 `sel` = 2, `sel_vld` = 1, `grant_start` = 1. Drop req[2] at cycle M → `sel_vld` = 0 at M+1, `ptr` = 3.
- Rotation: req = 4'b1111 held, `rel` pulsed on the 3rd cycle of each grant → `sel` sequence 0,1,2,3,0, each with `sel_vld` high 3 cycles followed by exactly one `sel_vld` = 0 cycle.
- Wrap-around: after granting channel 2 (`ptr` = 3), req = 4'b0011 → next grant is `sel` = 0, then `sel` = 1.
- Timeout (macro defined, MAX_HOLD = 8): req = 4'b0011 held → `sel` = 0 valid for exactly 8 cycles, `timeout` pulse, 1 dead cycle, then `sel` = 1 for 8 cycles. With `rel` and expiry in the same cycle → `timeout` stays 0. Macro undefined → `sel` = 0 held indefinitely and `timeout` stays 0.
- Reset mid-grant: rst_n low while `sel` = 3, `sel_vld` = 1 → `sel_vld` = 0 and `sel` = 0 immediately without waiting for a clock edge. After release with req = 4'b1010, first grant is `sel` = 1 (`ptr` = 0).

Source files
------------

// File: rtl/rr_dec_sel_arbiter.sv
// ---------------------------------------------------------------------------
// rr_dec_sel_arbiter
// Four-way round-robin arbiter that drives a 2-to-4 decoder. The output is a
// 2-bit index plus an enable instead of a one-hot vector. The arbiter always
// leaves one dead cycle (sel_vld = 0) between consecutive grants, so the
// decoder output goes break-before-make.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   req[3:0]     level-sensitive request per channel
//   rel          one-cycle release pulse from the current owner
//   sel[1:0]     granted channel index (decoder select)
//   sel_vld      grant valid (decoder enable)
//   grant_start  pulse in the first cycle of each grant
//   timeout      pulse after a grant is ended by hold expiry
//
// Build option
//   RR_HOLD_TIMEOUT_EN  when defined, limits each grant to MAX_HOLD cycles and
//                       drives timeout. When undefined, a grant lasts until
//                       the request drops or rel pulses, and timeout is 0.
// ---------------------------------------------------------------------------
module rr_dec_sel_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       rel,
   output logic [1:0] sel,
   output logic       sel_vld,
   output logic       grant_start,
   output logic       timeout
);

   // Catch out-of-range MAX_HOLD values at elaboration.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("rr_dec_sel_arbiter: MAX_HOLD must be within 2..255");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   state_e     state_q, state_d;

   logic [1:0] sel_q, sel_d;
   logic       sel_vld_q, sel_vld_d;
   logic       grant_start_q, grant_start_d;
   logic [1:0] ptr_q, ptr_d;

   logic [1:0] winner_c;
   logic [1:0] arb_idx_c;
   logic       req_any_c;
   logic       end_req_c;
   logic       end_rel_c;
   logic       end_c;

`ifdef RR_HOLD_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;
   logic              end_hold_c;
`endif

   // Rotating priority search: first set req bit at ptr, ptr+1, ... (mod 4).
   // The loop runs from the farthest offset down, so the nearest hit wins.
   always_comb begin
      winner_c  = ptr_q;
      arb_idx_c = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         arb_idx_c = ptr_q + 2'(i);
         if (req[arb_idx_c]) begin
            winner_c = arb_idx_c;
         end
      end
   end

   assign req_any_c = |req;

   // Grant end conditions; used only while in GRANT.
   assign end_req_c = ~req[sel_q];
   assign end_rel_c = rel;
`ifdef RR_HOLD_TIMEOUT_EN
   assign end_hold_c = (hold_q == HOLD_LAST);
   assign end_c      = end_req_c | end_rel_c | end_hold_c;
`else
   assign end_c      = end_req_c | end_rel_c;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic. GAP always lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_GAP: begin
            state_d = req_any_c ? S_GRANT : S_IDLE;
         end
         S_GRANT: begin
            if (end_c) begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM output / datapath next values. All outputs are registered.
   always_comb begin
      sel_d         = sel_q;
      sel_vld_d     = 1'b0;
      grant_start_d = 1'b0;
      ptr_d         = ptr_q;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_d        = hold_q;
      timeout_d     = 1'b0;
`endif
      unique case (state_q)
         S_IDLE, S_GAP: begin
            if (req_any_c) begin
               sel_d         = winner_c;
               sel_vld_d     = 1'b1;
               grant_start_d = 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
               hold_d        = '0;
`endif
            end
         end
         S_GRANT: begin
            if (end_c) begin
               // Next search starts just past the channel that held the grant.
               ptr_d = sel_q + 2'd1;
`ifdef RR_HOLD_TIMEOUT_EN
               // Release and request drop take precedence over expiry.
               timeout_d = end_hold_c & ~end_req_c & ~end_rel_c;
`endif
            end else begin
               sel_vld_d = 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
               hold_d    = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
`endif
            end
         end
         default: begin
            sel_vld_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q         <= 2'd0;
         sel_vld_q     <= 1'b0;
         grant_start_q <= 1'b0;
         ptr_q         <= 2'd0;
      end else begin
         sel_q         <= sel_d;
         sel_vld_q     <= sel_vld_d;
         grant_start_q <= grant_start_d;
         ptr_q         <= ptr_d;
      end
   end

`ifdef RR_HOLD_TIMEOUT_EN
   // Hold counter and timeout pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign sel         = sel_q;
   assign sel_vld     = sel_vld_q;
   assign grant_start = grant_start_q;

endmodule
